// File: rtl/had_bkpt_multi_ch.sv
// had_bkpt_multi_ch: multi-channel instruction breakpoint / data watchpoint unit
// in the debug domain. Each channel matches fetch PC or LSU address against a
// masked value, counts passes, optionally chains to its lower neighbour, and the
// lowest reporting channel is latched into a sticky hit vector.
module had_bkpt_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              forever_cpuclk,
  input  logic              hadrst,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic [31:0]       cfg_addr,
  input  logic [MASK_W-1:0] cfg_mask,
  input  logic [2:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_cnt,
  input  logic              cfg_chain,
  input  logic              hit_clr,
  input  logic              had_core_dbg_mode_req,
  input  logic [31:0]       ifu_had_match_pc,
  input  logic              ifu_had_split_first,
  input  logic              ifu_had_chg_flw_inst,
  input  logic              ifu_had_fetch_expt_vld,
  input  logic              ifu_had_inst_dbg_disable,
  input  logic              iu_had_xx_retire,
  input  logic              iu_had_xx_retire_normal,
  input  logic              iu_had_xx_mldst,
  input  logic              iu_had_flush,
  input  logic              iu_had_expt_vld,
  input  logic              iu_yy_xx_dbgon,
  input  logic [31:0]       lsu_had_addr,
  input  logic              lsu_had_addr_vld,
  input  logic              lsu_had_st,
  input  logic              lsu_had_ex_cmplt,
  output logic              had_ifu_inst_bkpt_req,
  output logic              had_iu_data_bkpt_req,
  output logic [NUM_CH-1:0] had_bkpt_hit_vec
);

  localparam logic [2:0] MODE_ID = 3'b001;
  localparam logic [2:0] MODE_I  = 3'b010;
  localparam logic [2:0] MODE_D  = 3'b011;
  localparam logic [2:0] MODE_CF = 3'b100;
  localparam logic [2:0] MODE_ST = 3'b101;
  localparam logic [2:0] MODE_LD = 3'b110;

  logic [31:0]       r_cfg_addr [NUM_CH];
  logic [MASK_W-1:0] r_cfg_mask [NUM_CH];
  logic [2:0]        r_cfg_mode [NUM_CH];
  logic [CNT_W-1:0]  r_cfg_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_cnt_cur  [NUM_CH];
  logic [NUM_CH-1:0] r_cfg_chain;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_arm;
  logic [NUM_CH-1:0] r_mldst_vec;
  logic              r_mldst_pend;

  logic [NUM_CH-1:0] w_cfg_sel, w_cfg_sel_up;
  logic [NUM_CH-1:0] w_match_pc, w_match_addr;
  logic [NUM_CH-1:0] w_raw_i, w_raw_d;
  logic [NUM_CH-1:0] w_chain_eff, w_arm_lo, w_armed;
  logic [NUM_CH-1:0] w_cand_i, w_cand_d, w_fire, w_fire_up;
  logic [NUM_CH-1:0] w_rep_i, w_rep_d;
  logic [NUM_CH-1:0] w_hv_src, w_hv_next;
  logic              w_gate_i, w_gate_d, w_data_req, w_hv_found;

  // Per-channel match, mode qualification, chain/counter resolution and requests.
  always_comb begin
    w_gate_i    = !ifu_had_fetch_expt_vld && !ifu_had_inst_dbg_disable && !iu_yy_xx_dbgon;
    w_gate_d    = !iu_yy_xx_dbgon && iu_had_xx_retire_normal;
    // Channel 0 has no lower neighbour, so its chain bit is never honoured.
    w_chain_eff    = r_cfg_chain;
    w_chain_eff[0] = 1'b0;
    w_arm_lo    = r_arm << 1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cfg_sel[i]    = cfg_wr && (cfg_ch == 3'(i));
      w_match_pc[i]   = (ifu_had_match_pc & {{(32-MASK_W){1'b1}}, r_cfg_mask[i]}) == r_cfg_addr[i];
      w_match_addr[i] = (lsu_had_addr & {{(32-MASK_W){1'b1}}, r_cfg_mask[i]}) == r_cfg_addr[i];
      w_raw_i[i] = (w_match_pc[i] && ifu_had_split_first && !had_core_dbg_mode_req &&
                    (r_cfg_mode[i] == MODE_ID || r_cfg_mode[i] == MODE_I)) ||
                   (r_cfg_mode[i] == MODE_CF && ifu_had_chg_flw_inst);
      w_raw_d[i] = ((w_match_addr[i] && lsu_had_addr_vld) || r_pend[i]) && iu_had_xx_retire &&
                   (r_cfg_mode[i] == MODE_ID || r_cfg_mode[i] == MODE_D ||
                    (r_cfg_mode[i] == MODE_ST && lsu_had_st) ||
                    (r_cfg_mode[i] == MODE_LD && !lsu_had_st));
      w_armed[i]  = !w_chain_eff[i] || w_arm_lo[i];
      // A channel being reconfigured this cycle must not act on its old settings.
      w_cand_i[i] = w_raw_i[i] && w_gate_i && !w_cfg_sel[i] && w_armed[i];
      w_cand_d[i] = w_raw_d[i] && w_gate_d && !w_cfg_sel[i] && w_armed[i];
      w_fire[i]   = (w_cand_i[i] || w_cand_d[i]) && (r_cnt_cur[i] == '0);
    end
    w_cfg_sel_up = w_cfg_sel >> 1;
    w_fire_up    = w_fire >> 1;
    // A channel that only arms its upper neighbour does not report on its own.
    w_rep_i = w_fire & w_cand_i & ~(w_chain_eff >> 1);
    w_rep_d = w_fire & w_cand_d & ~(w_chain_eff >> 1);
    had_ifu_inst_bkpt_req = |w_rep_i;
    w_data_req = !iu_had_xx_mldst &&
                 ((|w_rep_d) || (r_mldst_pend && iu_had_xx_retire && w_gate_d));
    had_iu_data_bkpt_req = w_data_req;
    w_hv_src   = had_ifu_inst_bkpt_req ? w_rep_i : (w_rep_d | r_mldst_vec);
    w_hv_next  = '0;
    w_hv_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hv_src[i] && !w_hv_found) begin
        w_hv_next[i] = 1'b1;
        w_hv_found   = 1'b1;
      end
    end
  end

  // Channel configuration, pass counters, pending address hits and chain arms.
  always_ff @(posedge forever_cpuclk or posedge hadrst) begin
    if (hadrst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cfg_addr[i] <= '0;
        r_cfg_mask[i] <= '0;
        r_cfg_mode[i] <= '0;
        r_cfg_cnt[i]  <= '0;
        r_cnt_cur[i]  <= '0;
      end
      r_cfg_chain <= '0;
      r_pend      <= '0;
      r_arm       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cfg_sel[i]) begin
          r_cfg_addr[i]  <= cfg_addr;
          r_cfg_mask[i]  <= cfg_mask;
          r_cfg_mode[i]  <= cfg_mode;
          r_cfg_cnt[i]   <= cfg_cnt;
          r_cfg_chain[i] <= cfg_chain;
          r_cnt_cur[i]   <= cfg_cnt;
        end else if (w_cand_i[i] || w_cand_d[i]) begin
          r_cnt_cur[i] <= (r_cnt_cur[i] == '0) ? r_cfg_cnt[i] : r_cnt_cur[i] - CNT_W'(1);
        end
        if (w_cfg_sel[i] || lsu_had_ex_cmplt || iu_had_flush)
          r_pend[i] <= 1'b0;
        else if (w_match_addr[i] && lsu_had_addr_vld)
          r_pend[i] <= 1'b1;
        if (w_cfg_sel[i] || w_cfg_sel_up[i] || iu_yy_xx_dbgon || w_fire_up[i])
          r_arm[i] <= 1'b0;
        else if (w_fire[i])
          r_arm[i] <= 1'b1;
      end
    end
  end

  // Deferred multi-ld/st watchpoint and sticky hit report.
  always_ff @(posedge forever_cpuclk or posedge hadrst) begin
    if (hadrst) begin
      r_mldst_pend     <= 1'b0;
      r_mldst_vec      <= '0;
      had_bkpt_hit_vec <= '0;
    end else begin
      if (w_data_req || iu_had_expt_vld) begin
        r_mldst_pend <= 1'b0;
        r_mldst_vec  <= '0;
      end else if ((|w_rep_d) && iu_had_xx_mldst) begin
        r_mldst_pend <= 1'b1;
        r_mldst_vec  <= r_mldst_vec | w_rep_d;
      end
      if (hit_clr)
        had_bkpt_hit_vec <= '0;
      else if (had_ifu_inst_bkpt_req || w_data_req)
        had_bkpt_hit_vec <= w_hv_next;
    end
  end

endmodule

// File: tb/tb_had_bkpt_multi_ch.sv
// Scoreboard bench for had_bkpt_multi_ch: each stimulus cycle pushes its expected
// request/hit-vector result, which is popped and compared once the DUT responds.
module tb_had_bkpt_multi_ch;

  logic        clk = 1'b0;
  logic        hadrst;
  logic        cfg_wr;
  logic [2:0]  cfg_ch;
  logic [31:0] cfg_addr;
  logic [7:0]  cfg_mask;
  logic [2:0]  cfg_mode;
  logic [7:0]  cfg_cnt;
  logic        cfg_chain;
  logic        hit_clr;
  logic        dmreq;
  logic [31:0] pc;
  logic        split, chg, fexpt, idis;
  logic        retire, rnorm, mldst, flush, expt, dbgon;
  logic [31:0] addr;
  logic        avld, st, cmplt;
  logic        inst_req, data_req;
  logic [3:0]  hit_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic split, chg, fexpt, idis, dmreq;
    logic [31:0] addr;
    logic avld, st, cmplt;
    logic retire, rnorm, mldst, flush, expt, dbgon, clr;
    logic e_inst, e_data;
    logic [3:0] e_hv;
  } stim_t;

  typedef struct {
    logic inst, data;
    logic [3:0] hv;
  } exp_t;

  exp_t sb[$];

  had_bkpt_multi_ch #(.NUM_CH(4), .MASK_W(8), .CNT_W(8)) dut (
    .forever_cpuclk(clk), .hadrst(hadrst),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask),
    .cfg_mode(cfg_mode), .cfg_cnt(cfg_cnt), .cfg_chain(cfg_chain), .hit_clr(hit_clr),
    .had_core_dbg_mode_req(dmreq), .ifu_had_match_pc(pc), .ifu_had_split_first(split),
    .ifu_had_chg_flw_inst(chg), .ifu_had_fetch_expt_vld(fexpt),
    .ifu_had_inst_dbg_disable(idis), .iu_had_xx_retire(retire),
    .iu_had_xx_retire_normal(rnorm), .iu_had_xx_mldst(mldst), .iu_had_flush(flush),
    .iu_had_expt_vld(expt), .iu_yy_xx_dbgon(dbgon), .lsu_had_addr(addr),
    .lsu_had_addr_vld(avld), .lsu_had_st(st), .lsu_had_ex_cmplt(cmplt),
    .had_ifu_inst_bkpt_req(inst_req), .had_iu_data_bkpt_req(data_req),
    .had_bkpt_hit_vec(hit_vec)
  );

  initial forever #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t fetch(logic [31:0] a);
    stim_t s;
    s = idle();
    s.pc = a;
    s.split = 1'b1;
    return s;
  endfunction

  function automatic stim_t acc(logic [31:0] a, logic is_st);
    stim_t s;
    s = idle();
    s.addr = a; s.avld = 1'b1; s.st = is_st; s.cmplt = 1'b1;
    s.retire = 1'b1; s.rnorm = 1'b1;
    return s;
  endfunction

  function automatic stim_t ret(logic m);
    stim_t s;
    s = idle();
    s.retire = 1'b1; s.rnorm = 1'b1; s.mldst = m;
    return s;
  endfunction

  function automatic stim_t clr();
    stim_t s;
    s = idle();
    s.clr = 1'b1;
    return s;
  endfunction

  function automatic stim_t ex(stim_t s, logic i, logic d, logic [3:0] hv);
    stim_t r;
    r = s;
    r.e_inst = i; r.e_data = d; r.e_hv = hv;
    return r;
  endfunction

  task automatic idle_in();
    cfg_wr = 0; cfg_ch = 0; cfg_addr = 0; cfg_mask = 0; cfg_mode = 0; cfg_cnt = 0;
    cfg_chain = 0; hit_clr = 0; dmreq = 0; pc = 0; split = 0; chg = 0; fexpt = 0;
    idis = 0; retire = 0; rnorm = 0; mldst = 0; flush = 0; expt = 0; dbgon = 0;
    addr = 0; avld = 0; st = 0; cmplt = 0;
  endtask

  // Drives one cycle of stimulus and records what the DUT must answer.
  task automatic apply(stim_t s);
    exp_t e;
    pc = s.pc; split = s.split; chg = s.chg; fexpt = s.fexpt; idis = s.idis;
    dmreq = s.dmreq; addr = s.addr; avld = s.avld; st = s.st; cmplt = s.cmplt;
    retire = s.retire; rnorm = s.rnorm; mldst = s.mldst; flush = s.flush;
    expt = s.expt; dbgon = s.dbgon; hit_clr = s.clr; cfg_wr = 1'b0;
    e.inst = s.e_inst; e.data = s.e_data; e.hv = s.e_hv;
    sb.push_back(e);
  endtask

  task automatic cfg(logic [2:0] ch, logic [31:0] a, logic [7:0] m, logic [2:0] md,
                     logic [7:0] c, logic chn);
    idle_in();
    cfg_wr = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_mask = m; cfg_mode = md;
    cfg_cnt = c; cfg_chain = chn;
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic test_reset();
    stim_t v[$];
    exp_t e;
    checks++;
    if ({inst_req, data_req, hit_vec} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b%b %b want 00 0000", inst_req, data_req, hit_vec);
    end
    hadrst = 1'b0;
    @(posedge clk); #1;
    v.push_back(ex(acc(32'h0, 1'b0), 0, 0, 4'h0));
    v.push_back(ex(fetch(32'h0), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL reset[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL reset[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  task automatic test_inst_bkpt();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd0, 32'h1000, 8'hFF, 3'b010, 8'd0, 1'b0);
    v.push_back(ex(fetch(32'h1004), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL inst_full_mask req got %b%b want %b%b", inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL inst_full_mask hit_vec got %b want %b", hit_vec, e.hv);
      end
    end
    cfg(3'd0, 32'h1000, 8'hF8, 3'b010, 8'd0, 1'b0);
    v.delete();
    v.push_back(ex(fetch(32'h1004), 1, 0, 4'h1));
    s = fetch(32'h1004); s.split = 1'b0;  v.push_back(ex(s, 0, 0, 4'h1));
    s = fetch(32'h1004); s.idis = 1'b1;   v.push_back(ex(s, 0, 0, 4'h1));
    s = fetch(32'h1004); s.dmreq = 1'b1;  v.push_back(ex(s, 0, 0, 4'h1));
    s = fetch(32'h1004); s.clr = 1'b1;    v.push_back(ex(s, 1, 0, 4'h0));
    v.push_back(ex(idle(), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL inst[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL inst[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
    cfg(3'd0, 32'h0, 8'h00, 3'b100, 8'd0, 1'b0);
    v.delete();
    s = idle(); s.pc = 32'h1234; s.chg = 1'b1; v.push_back(ex(s, 1, 0, 4'h1));
    s = idle(); s.pc = 32'h1234;               v.push_back(ex(s, 0, 0, 4'h1));
    s = idle(); s.chg = 1'b1; s.fexpt = 1'b1;  v.push_back(ex(s, 0, 0, 4'h1));
    v.push_back(ex(clr(), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL chg_flw[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL chg_flw[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
    cfg(3'd0, 32'h0, 8'h00, 3'b000, 8'd0, 1'b0);
  endtask

  task automatic test_counter();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd1, 32'h4000, 8'hFF, 3'b101, 8'd2, 1'b0);
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 0, 4'h0));
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 0, 4'h0));
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 1, 4'h2));
    v.push_back(ex(acc(32'h4000, 1'b0), 0, 0, 4'h2));
    s = acc(32'h4000, 1'b1); s.rnorm = 1'b0; v.push_back(ex(s, 0, 0, 4'h2));
    s = acc(32'h4000, 1'b1); s.dbgon = 1'b1; v.push_back(ex(s, 0, 0, 4'h2));
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 0, 4'h2));
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 0, 4'h2));
    v.push_back(ex(acc(32'h4000, 1'b1), 0, 1, 4'h2));
    v.push_back(ex(clr(), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL counter[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL counter[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  task automatic test_chain();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd1, 32'h2000, 8'hFF, 3'b010, 8'd0, 1'b0);
    cfg(3'd2, 32'h3000, 8'hFF, 3'b011, 8'd0, 1'b1);
    v.push_back(ex(acc(32'h3000, 1'b0), 0, 0, 4'h0));
    v.push_back(ex(fetch(32'h2000), 0, 0, 4'h0));
    v.push_back(ex(acc(32'h3000, 1'b0), 0, 1, 4'h4));
    v.push_back(ex(acc(32'h3000, 1'b0), 0, 0, 4'h4));
    v.push_back(ex(fetch(32'h2000), 0, 0, 4'h4));
    s = idle(); s.dbgon = 1'b1; v.push_back(ex(s, 0, 0, 4'h4));
    v.push_back(ex(acc(32'h3000, 1'b0), 0, 0, 4'h4));
    v.push_back(ex(clr(), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL chain[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL chain[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
    cfg(3'd1, 32'h0, 8'h00, 3'b000, 8'd0, 1'b0);
    cfg(3'd2, 32'h0, 8'h00, 3'b000, 8'd0, 1'b0);
  endtask

  task automatic test_mldst();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd3, 32'h5000, 8'hFF, 3'b011, 8'd0, 1'b0);
    s = acc(32'h5000, 1'b0); s.mldst = 1'b1; v.push_back(ex(s, 0, 0, 4'h0));
    v.push_back(ex(ret(1'b1), 0, 0, 4'h0));
    v.push_back(ex(ret(1'b0), 0, 1, 4'h8));
    s = acc(32'h5000, 1'b0); s.mldst = 1'b1; v.push_back(ex(s, 0, 0, 4'h8));
    s = idle(); s.expt = 1'b1;               v.push_back(ex(s, 0, 0, 4'h8));
    v.push_back(ex(ret(1'b0), 0, 0, 4'h8));
    v.push_back(ex(clr(), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL mldst[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL mldst[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  task automatic test_pend();
    stim_t v[$];
    stim_t s;
    exp_t e;
    s = idle(); s.addr = 32'h5000; s.avld = 1'b1; v.push_back(ex(s, 0, 0, 4'h0));
    s = ret(1'b0); s.cmplt = 1'b1;                v.push_back(ex(s, 0, 1, 4'h8));
    v.push_back(ex(clr(), 0, 0, 4'h0));
    s = idle(); s.addr = 32'h5000; s.avld = 1'b1; v.push_back(ex(s, 0, 0, 4'h0));
    s = idle(); s.cmplt = 1'b1; s.flush = 1'b1;   v.push_back(ex(s, 0, 0, 4'h0));
    v.push_back(ex(ret(1'b0), 0, 0, 4'h0));
    s = idle(); s.addr = 32'h5000; s.avld = 1'b1; s.flush = 1'b1; v.push_back(ex(s, 0, 0, 4'h0));
    v.push_back(ex(ret(1'b0), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL pend[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL pend[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd0, 32'h1000, 8'hFF, 3'b010, 8'd0, 1'b0);
    cfg(3'd1, 32'h7000, 8'hFF, 3'b011, 8'd0, 1'b0);
    cfg(3'd2, 32'h7000, 8'hFF, 3'b011, 8'd0, 1'b0);
    cfg(3'd5, 32'h6000, 8'hFF, 3'b011, 8'd0, 1'b0);
    s = acc(32'h7000, 1'b0); s.pc = 32'h1000; s.split = 1'b1; v.push_back(ex(s, 1, 1, 4'h1));
    v.push_back(ex(acc(32'h7000, 1'b1), 0, 1, 4'h2));
    v.push_back(ex(acc(32'h6000, 1'b0), 0, 0, 4'h2));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL b2b[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL b2b[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t v[$];
    stim_t s;
    exp_t e;
    cfg(3'd1, 32'h4000, 8'hFF, 3'b101, 8'd2, 1'b0);
    s = acc(32'h4000, 1'b1); s.cmplt = 1'b0; v.push_back(ex(s, 0, 0, 4'h2));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL rst_mid_pre req got %b%b want %b%b", inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL rst_mid_pre hit_vec got %b want %b", hit_vec, e.hv);
      end
    end
    s = acc(32'h4000, 1'b1); s.cmplt = 1'b0; s.pc = 32'h1000; s.split = 1'b1;
    apply(s);
    e = sb.pop_front();
    #2;
    checks++;
    if ({inst_req, data_req} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_live req got %b%b want 10", inst_req, data_req);
    end
    hadrst = 1'b1;
    #1;
    checks++;
    if ({inst_req, data_req, hit_vec} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid_async got %b%b %b want 00 0000", inst_req, data_req, hit_vec);
    end
    @(negedge clk);
    hadrst = 1'b0;
    @(posedge clk); #1;
    v.delete();
    v.push_back(ex(s, 0, 0, 4'h0));
    v.push_back(ex(acc(32'h7000, 1'b0), 0, 0, 4'h0));
    foreach (v[k]) begin
      apply(v[k]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_req, data_req} !== {e.inst, e.data}) begin
        errors++;
        $display("FAIL rst_mid_post[%0d] req got %b%b want %b%b", k, inst_req, data_req, e.inst, e.data);
      end
      @(posedge clk); #1;
      checks++;
      if (hit_vec !== e.hv) begin
        errors++;
        $display("FAIL rst_mid_post[%0d] hit_vec got %b want %b", k, hit_vec, e.hv);
      end
    end
  endtask

  initial begin
    idle_in();
    hadrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_inst_bkpt();
    test_counter();
    test_chain();
    test_mldst();
    test_pend();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
